// File: rtl/rns_32_17_13_11_pkg.sv
// Shared constants for the (32,17,13,11) RNS set: moduli, MRC inverses, mixed-radix weights, FSM states.
package rns_32_17_13_11_pkg;
  localparam int M0 = 32;
  localparam int M1 = 17;
  localparam int M2 = 13;
  localparam int M3 = 11;
  localparam int M_TOTAL = 77792;

  localparam int W0 = 5;
  localparam int W1 = 5;
  localparam int W2 = 4;
  localparam int W3 = 4;

  // INV_jk = (m_k)^-1 mod m_j
  localparam int INV_10 = 8;
  localparam int INV_20 = 11;
  localparam int INV_30 = 10;
  localparam int INV_21 = 10;
  localparam int INV_31 = 2;
  localparam int INV_32 = 6;

  localparam int WT1 = 32;
  localparam int WT2 = 544;
  localparam int WT3 = 7072;

  typedef enum logic [2:0] {IDLE, D1, D2, D3, ACC, OUT} state_e;
endpackage

// File: rtl/rns2bin_mrc_seq_32_17_13_11_mod_sub_mul.sv
// Combinational ((a - b mod M) * C) mod M; both operands are folded into [0,M) first.
module mod_sub_mul #(
  parameter int M  = 17,
  parameter int C  = 8,
  parameter int AW = 5,
  parameter int BW = 5,
  parameter int OW = 5
) (
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  output logic [OW-1:0] y
);
  logic [7:0] ar, br, d, p, pm;

  // Folding a as well keeps the product within 8 bits even for illegal residues.
  always_comb begin
    ar = 8'(a) % 8'(M);
    br = 8'(b) % 8'(M);
    d  = (ar >= br) ? (ar - br) : (ar + 8'(M) - br);
    p  = d * 8'(C);
    pm = p % 8'(M);
    y  = OW'(pm);
  end
endmodule

// File: rtl/rns2bin_mrc_seq_32_17_13_11.sv
// Sequential MRC decoder: one mixed-radix digit resolved per cycle, result held until consumed.
module rns2bin_mrc_seq_32_17_13_11
  import rns_32_17_13_11_pkg::*;
#(
  parameter int DYN_SIZE = 16,
  parameter int MAX_MOD  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAX_MOD-1:0]  x0,
  input  logic [W1-1:0]       x1,
  input  logic [W2-1:0]       x2,
  input  logic [W3-1:0]       x3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DYN_SIZE:0]   N_out,
  output logic                err
);
  state_e state_q, state_d;
  logic [W0-1:0] r0_q;
  logic [W1-1:0] r1_q, d1_r1;
  logic [W2-1:0] r2_q, d1_r2, d2_r2;
  logic [W3-1:0] r3_q, d1_r3, d2_r3, d3_r3;
  logic          err_q, err_out_q;
  logic [DYN_SIZE:0] n_q, n_sum;

  mod_sub_mul #(.M(M1), .C(INV_10), .AW(W1), .BW(W0), .OW(W1)) u_d1_1 (.a(r1_q), .b(r0_q), .y(d1_r1));
  mod_sub_mul #(.M(M2), .C(INV_20), .AW(W2), .BW(W0), .OW(W2)) u_d1_2 (.a(r2_q), .b(r0_q), .y(d1_r2));
  mod_sub_mul #(.M(M3), .C(INV_30), .AW(W3), .BW(W0), .OW(W3)) u_d1_3 (.a(r3_q), .b(r0_q), .y(d1_r3));
  mod_sub_mul #(.M(M2), .C(INV_21), .AW(W2), .BW(W1), .OW(W2)) u_d2_2 (.a(r2_q), .b(r1_q), .y(d2_r2));
  mod_sub_mul #(.M(M3), .C(INV_31), .AW(W3), .BW(W1), .OW(W3)) u_d2_3 (.a(r3_q), .b(r1_q), .y(d2_r3));
  mod_sub_mul #(.M(M3), .C(INV_32), .AW(W3), .BW(W2), .OW(W3)) u_d3_3 (.a(r3_q), .b(r2_q), .y(d3_r3));

  // Digits stay in place once resolved: a0=r0, a1=r1 after D1, a2=r2 after D2, a3=r3 after D3.
  assign n_sum = (DYN_SIZE+1)'(r0_q)
               + (DYN_SIZE+1)'(r1_q) * (DYN_SIZE+1)'(WT1)
               + (DYN_SIZE+1)'(r2_q) * (DYN_SIZE+1)'(WT2)
               + (DYN_SIZE+1)'(r3_q) * (DYN_SIZE+1)'(WT3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = D1;
      D1:      state_d = D2;
      D2:      state_d = D3;
      D3:      state_d = ACC;
      ACC:     state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r0_q      <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      r3_q      <= '0;
      err_q     <= 1'b0;
      err_out_q <= 1'b0;
      n_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          r0_q  <= x0;
          r1_q  <= x1;
          r2_q  <= x2;
          r3_q  <= x3;
          err_q <= (x1 > W1'(16)) | (x2 > W2'(12)) | (x3 > W3'(10));
        end
        D1: begin
          r1_q <= d1_r1;
          r2_q <= d1_r2;
          r3_q <= d1_r3;
        end
        D2: begin
          r2_q <= d2_r2;
          r3_q <= d2_r3;
        end
        D3:  r3_q <= d3_r3;
        ACC: begin
          n_q       <= err_q ? '0 : n_sum;
          err_out_q <= err_q;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign N_out     = n_q;
  assign err       = err_out_q;
endmodule

// File: tb/tb_rns2bin_mrc_seq_32_17_13_11.sv
// Directed bench for the MRC decoder: hand-computed vectors, backpressure, error flag, mid-flight reset.
module tb_rns2bin_mrc_seq_32_17_13_11;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  x0;
  logic [4:0]  x1;
  logic [3:0]  x2;
  logic [3:0]  x3;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] N_out;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  int lat;

  rns2bin_mrc_seq_32_17_13_11 dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .out_valid(out_valid), .out_ready(out_ready), .N_out(N_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Present a word and let it be taken on the next rising edge; returns 1ns after that edge.
  task automatic send(input int a, input int b, input int c, input int d);
    @(negedge clk);
    x0 = 5'(a); x1 = 5'(b); x2 = 4'(c); x3 = 4'(d);
    in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Edges from the accepting edge until out_valid is seen, bounded.
  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!out_valid && n < 20);
  endtask

  task automatic run(input string tag, input int a, input int b, input int c, input int d,
                     input int exp_n, input int exp_err);
    int l;
    send(a, b, c, d);
    wait_out(l);
    chk({tag, "_latency"}, 32'(l), 32'd4);
    chk({tag, "_N_out"}, 32'(N_out), 32'(exp_n));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    @(posedge clk);
    #1;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x0 = '0; x1 = '0; x2 = '0; x3 = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_N_out", 32'(N_out), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b1;

    run("zero", 0, 0, 0, 0, 0, 0);
    run("n12345", 25, 3, 8, 3, 12345, 0);
    run("nmax", 31, 16, 12, 10, 77791, 0);
    run("n1000", 8, 14, 12, 10, 1000, 0);
    run("n50000", 16, 3, 2, 5, 50000, 0);

    // Strided sweep with the forward conversion computed by plain remainders.
    for (int k = 0; k < 120; k++) begin
      int n;
      n = (k * 647 + 13) % 77792;
      run("sweep", n % 32, n % 17, n % 13, n % 11, n, 0);
    end

    // Backpressure: result must hold while a second word waits, unsampled.
    out_ready = 1'b0;
    send(0, 15, 6, 10);
    wait_out(lat);
    chk("bp_latency", 32'(lat), 32'd4);
    chk("bp_N_out", 32'(N_out), 32'd32);
    @(negedge clk);
    x0 = 5'd8; x1 = 5'd14; x2 = 4'd12; x3 = 4'd10;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_N_out", 32'(N_out), 32'd32);
      chk("bp_hold_err", 32'(err), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_handshake_valid", 32'(out_valid), 32'd0);
    chk("bp_handshake_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(lat);
    chk("bp_next_latency", 32'(lat), 32'd4);
    chk("bp_next_N_out", 32'(N_out), 32'd1000);
    @(posedge clk);
    #1;
    chk("bp_next_drop", 32'(out_valid), 32'd0);

    // Out-of-range residues flag err and zero the result.
    run("err_x1", 0, 17, 0, 0, 0, 1);
    run("err_x2", 0, 0, 13, 0, 0, 1);
    run("err_x3", 7, 3, 2, 11, 0, 1);
    run("legal_after_err", 1, 1, 1, 1, 1, 0);

    // Reset while in D2.
    send(5, 5, 5, 5);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_N_out", 32'(N_out), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_output", 32'(out_valid), 32'd0);
    end
    run("after_rst", 2, 2, 2, 2, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rns2bin_mrc_seq_32_17_13_11.md
Name: rns2bin_mrc_seq_32_17_13_11

Overview:
Sequential mixed-radix (MRC) RNS-to-binary decoder for the moduli set (32, 17, 13, 11), dynamic range M = 77792. It is the receive-side counterpart of the BIN2RNS_32_17_13_11 forward converter and needs no LUT or characteristic-matrix inputs. It uses one modular subtract-multiply per channel per cycle, with valid/ready handshakes on both sides. It sits after RNS datapath stages and returns 17-bit binary results.

Parameters:
DYN_SIZE, 16, output is DYN_SIZE+1 bits wide (matches the existing N_out width).
MAX_MOD, 5, width of the widest residue port.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  residue word valid
in_ready  output  1  block can accept a residue word
x0  input  5  residue mod 32
x1  input  5  residue mod 17
x2  input  4  residue mod 13
x3  input  4  residue mod 11
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
N_out  output  17  reconstructed binary value, 0..77791
err  output  1  qualifies N_out: at least one input residue was out of range

Behaviour:
- One clock (clk). Reset is asynchronous and active-low on the port named reset.
- Reset (reset=0), effective immediately:
  - state=IDLE, in_ready=1, out_valid=0, N_out=0, err=0, internal registers 0.
  - Reset mid-conversion abandons the conversion; no output is produced.
- FSM states: IDLE, D1, D2, D3, ACC, OUT.
- IDLE: in_ready=1.
  - On in_valid&&in_ready, latch r0..r3 = x0..x3.
  - Set err_q = (x1>16)|(x2>12)|(x3>10). x0 is always legal.
  - Go to D1.
- D1: a0=r0. r1=((r1-a0)*8) mod 17; r2=((r2-a0)*11) mod 13; r3=((r3-a0)*10) mod 11. Go to D2.
- D2: a1=r1. r2=((r2-a1)*10) mod 13; r3=((r3-a1)*2) mod 11. Go to D3.
- D3: a2=r2. r3=((r3-a2)*6) mod 11. Go to ACC.
- ACC: a3=r3.
  - Register N_out = a0 + 32*a1 + 544*a2 + 7072*a3, or 0 if err_q.
  - Register err = err_q, set out_valid=1, go to OUT.
- Modular subtraction: the subtrahend is reduced mod m_j first (a0 up to 31 against m=17/13/11). The difference is taken non-negative by adding m_j before multiplying. No intermediate value exceeds 8 bits.
- Latency: out_valid rises on the 4th rising edge after the accepting edge.
- OUT:
  - out_valid=1. N_out and err are held stable until out_ready=1.
  - On out_valid&&out_ready: out_valid=0 next edge, go to IDLE.
- in_ready is 0 in every state except IDLE. Input is never accepted in the same cycle as the output handshake. Minimum initiation interval: 6 cycles.
- in_valid asserted while in_ready=0 is ignored; x0..x3 are not sampled.
- N_out and err change only on the ACC edge or on reset.

Decomposition:
- Package rns_32_17_13_11_pkg:
  - moduli M0..M3 = 32, 17, 13, 11; M_TOTAL = 77792.
  - MRC inverse constants 8, 11, 10, 10, 2, 6.
  - MRC weights 32, 544, 7072.
  - residue width localparams.
  - FSM state enum.
- Sub-module mod_sub_mul: combinational ((a - b mod M) * C) mod M, with M and C as parameters. Instantiated once per (channel, step), six in total.

Test Plan:
- After reset, x=(0,0,0,0), out_ready=1 -> out_valid 4 edges after accept, N_out=0, err=0.
- x=(25,3,8,3) -> N_out=12345, err=0.
- x=(31,16,12,10) -> N_out=77791, err=0. Sweep every N in 0..77791 through BIN2RNS_32_17_13_11 into this block -> N_out==N for all.
- Backpressure: out_ready=0 for 10 cycles with in_valid held high -> N_out and err stable, in_ready=0 throughout. out_ready=1 -> one handshake, then return to IDLE and accept the next word.
- x=(0,17,0,0) -> err=1, N_out=0. Next legal word x=(1,1,1,1) -> err=0, N_out=1.
- Assert reset=0 during D2 -> out_valid=0, in_ready=1 immediately. After release, new input x=(2,2,2,2) -> N_out=2.
